// File: rtl/decoder_3to8_seq.sv
// -----------------------------------------------------------------------------
// decoder_3to8_seq
//
// Queued, time-sequenced 3-to-8 one-hot decoder. Commands ({in_en, in_code})
// are written into a small FIFO. A three-state sequencer (IDLE/DRIVE/GAP)
// pops them one at a time. Each command drives its one-hot word on y for
// HOLD_CYCLES cycles, followed by GAP_CYCLES idle cycles with y = 0. A blank
// command (in_en = 0) holds y = 0 with y_valid = 1 for the hold period.
//
// Parameters
//   HOLD_CYCLES  cycles each decoded word is driven          (1..255)
//   GAP_CYCLES   idle cycles with y = 0 between words        (0..255)
//   FIFO_DEPTH   command queue entries                       (power of 2, 2..16)
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   command present
//   in_ready    out  queue can accept a command (fifo_count < FIFO_DEPTH)
//   in_code     in   [2:0] binary index to decode
//   in_en       in   command enable; 0 = blank slot
//   clear       in   synchronous flush of queue and sequencer (top priority)
//   y           out  [7:0] registered one-hot word
//   y_valid     out  high while y carries a command's hold period
//   busy        out  sequencer not IDLE or queue non-empty
//   fifo_count  out  [$clog2(FIFO_DEPTH):0] number of queued entries
// -----------------------------------------------------------------------------
module decoder_3to8_seq #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2:0]                    in_code,
    input  logic                          in_en,
    input  logic                          clear,
    output logic [7:0]                    y,
    output logic                          y_valid,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]       HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    // Only used when GAP_CYCLES > 0, so the wrap at GAP_CYCLES = 0 is harmless.
    localparam logic [7:0]       GAP_LOAD  = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Queue entry: {en, code}
    typedef struct packed {
        logic       en;
        logic [2:0] code;
    } entry_t;

    // ------------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------------
    entry_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;

    logic               push;
    logic               pop;
    logic               pop_req;
    logic               fifo_empty;
    entry_t             head;

    assign in_ready   = (count_q < DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign head       = mem[rd_ptr];

    // clear drops any concurrent push or pop.
    assign push = in_valid && in_ready && !clear;
    assign pop  = pop_req && !clear;

    // NOTE: the storage array carries no reset; emptiness is defined by the
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry_t'{en: in_en, code: in_code};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign fifo_count = count_q;

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [7:0] hold_q,  hold_d;
    logic [7:0] gap_q,   gap_d;
    logic [7:0] y_q,     y_d;
    logic       yv_q,    yv_d;

    function automatic logic [7:0] decode(input entry_t e);
        return e.en ? (8'h01 << e.code) : 8'h00;
    endfunction

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        y_d     = y_q;
        yv_d    = yv_q;
        pop_req = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_req = 1'b1;
                    state_d = ST_DRIVE;
                    hold_d  = HOLD_LOAD;
                    y_d     = decode(head);
                    yv_d    = 1'b1;
                end
            end

            ST_DRIVE: begin
                if (hold_q != 8'd0) begin
                    hold_d = hold_q - 8'd1;
                end else if (GAP_CYCLES > 0) begin
                    state_d = ST_GAP;
                    gap_d   = GAP_LOAD;
                    y_d     = 8'h00;
                    yv_d    = 1'b0;
                end else if (!fifo_empty) begin
                    // Back-to-back: next word follows with no bubble.
                    pop_req = 1'b1;
                    hold_d  = HOLD_LOAD;
                    y_d     = decode(head);
                    yv_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    y_d     = 8'h00;
                    yv_d    = 1'b0;
                end
            end

            ST_GAP: begin
                if (gap_q != 8'd0) begin
                    gap_d = gap_q - 8'd1;
                end else if (!fifo_empty) begin
                    pop_req = 1'b1;
                    state_d = ST_DRIVE;
                    hold_d  = HOLD_LOAD;
                    y_d     = decode(head);
                    yv_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                y_d     = 8'h00;
                yv_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= 8'd0;
            gap_q   <= 8'd0;
            y_q     <= 8'h00;
            yv_q    <= 1'b0;
        end else if (clear) begin
            state_q <= ST_IDLE;
            hold_q  <= 8'd0;
            gap_q   <= 8'd0;
            y_q     <= 8'h00;
            yv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
        end
    end

    assign y       = y_q;
    assign y_valid = yv_q;
    assign busy    = (state_q != ST_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// -----------------------------------------------------------------------------
// tb_decoder_3to8_seq
//
// Directed bench for decoder_3to8_seq. Instance "dut" uses default parameters;
// instance "dut_b" uses HOLD_CYCLES=1, GAP_CYCLES=0 for the gapless case.
// Inputs change 1 time unit after the rising edge, outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_decoder_3to8_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // default-parameter instance
    logic       in_valid = 1'b0;
    logic       in_en = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] in_code = 3'd0;
    logic       in_ready;
    logic [7:0] y;
    logic       y_valid;
    logic       busy;
    logic [2:0] fifo_count;

    // HOLD=1, GAP=0 instance
    logic       b_in_valid = 1'b0;
    logic       b_in_en = 1'b0;
    logic       b_clear = 1'b0;
    logic [2:0] b_in_code = 3'd0;
    logic       b_in_ready;
    logic [7:0] b_y;
    logic       b_y_valid;
    logic       b_busy;
    logic [2:0] b_fifo_count;

    int tests = 0;
    int fails = 0;

    decoder_3to8_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_en      (in_en),
        .clear      (clear),
        .y          (y),
        .y_valid    (y_valid),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    decoder_3to8_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .FIFO_DEPTH(4)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_code    (b_in_code),
        .in_en      (b_in_en),
        .clear      (b_clear),
        .y          (b_y),
        .y_valid    (b_y_valid),
        .busy       (b_busy),
        .fifo_count (b_fifo_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        #2;
        tests++;
        if ({y_valid, y, fifo_count, busy, in_ready} !== {1'b0, 8'h00, 3'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_state: got yv=%b y=%h cnt=%0d busy=%b rdy=%b, want 0 00 0 0 1",
                     y_valid, y, fifo_count, busy, in_ready);
        end
        step();
        step();
        rst_n = 1'b1;
        #1;
        tests++;
        if ({y_valid, y, fifo_count, busy} !== {1'b0, 8'h00, 3'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_release: got yv=%b y=%h cnt=%0d busy=%b, want 0 00 0 0",
                     y_valid, y, fifo_count, busy);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_single();
        in_valid = 1'b1; in_code = 3'd5; in_en = 1'b1;
        step();                                   // accept
        in_valid = 1'b0;
        tests++;
        if ({y_valid, fifo_count, busy} !== {1'b0, 3'd1, 1'b1}) begin
            fails++;
            $display("FAIL single_queued: got yv=%b cnt=%0d busy=%b, want 0 1 1",
                     y_valid, fifo_count, busy);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if ({y_valid, y} !== {1'b1, 8'h20}) begin
                fails++;
                $display("FAIL single_drive[%0d]: got yv=%b y=%h, want 1 20", i, y_valid, y);
            end
        end
        step();
        tests++;
        if ({y_valid, y, busy} !== {1'b0, 8'h00, 1'b1}) begin
            fails++;
            $display("FAIL single_gap: got yv=%b y=%h busy=%b, want 0 00 1", y_valid, y, busy);
        end
        step();
        tests++;
        if ({y_valid, y, busy} !== {1'b0, 8'h00, 1'b0}) begin
            fails++;
            $display("FAIL single_idle: got yv=%b y=%h busy=%b, want 0 00 0", y_valid, y, busy);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        int         idx = 0;
        bit         acc;
        bit         exp_v;
        logic [7:0] exp_y;
        for (int n = 1; n <= 42; n++) begin
            in_valid = (idx < 8);
            in_code  = idx[2:0];
            in_en    = 1'b1;
            acc      = in_valid && in_ready;
            step();
            if (acc) idx++;
            // Word k is driven after edges 2+5k .. 5+5k, gap after edge 6+5k.
            exp_v = (n >= 2) && (n <= 41) && (((n - 2) % 5) != 4);
            exp_y = exp_v ? (8'h01 << ((n - 2) / 5)) : 8'h00;
            tests++;
            if ({y_valid, y} !== {exp_v, exp_y}) begin
                fails++;
                $display("FAIL b2b_out edge %0d: got yv=%b y=%h, want %b %h",
                         n, y_valid, y, exp_v, exp_y);
            end
            if (n == 5) begin
                tests++;
                if ({in_ready, fifo_count} !== {1'b0, 3'd4}) begin
                    fails++;
                    $display("FAIL b2b_full: got rdy=%b cnt=%0d, want 0 4", in_ready, fifo_count);
                end
            end
        end
        in_valid = 1'b0;
        tests++;
        if (idx !== 8 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_done: got accepted=%0d busy=%b, want 8 0", idx, busy);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_gapless();
        b_in_valid = 1'b1; b_in_code = 3'd3; b_in_en = 1'b1;
        step();
        b_in_code = 3'd6;
        step();                                   // push 6, pop 3
        b_in_valid = 1'b0;
        tests++;
        if ({b_y_valid, b_y, b_fifo_count} !== {1'b1, 8'h08, 3'd1}) begin
            fails++;
            $display("FAIL gapless_first: got yv=%b y=%h cnt=%0d, want 1 08 1",
                     b_y_valid, b_y, b_fifo_count);
        end
        step();
        tests++;
        if ({b_y_valid, b_y} !== {1'b1, 8'h40}) begin
            fails++;
            $display("FAIL gapless_second: got yv=%b y=%h, want 1 40", b_y_valid, b_y);
        end
        step();
        tests++;
        if ({b_y_valid, b_y, b_busy} !== {1'b0, 8'h00, 1'b0}) begin
            fails++;
            $display("FAIL gapless_idle: got yv=%b y=%h busy=%b, want 0 00 0", b_y_valid, b_y, b_busy);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_blank();
        in_valid = 1'b1; in_code = 3'd2; in_en = 1'b0;
        step();
        in_en = 1'b1;
        step();                                   // push enabled, pop blank
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            tests++;
            if ({y_valid, y} !== {1'b1, 8'h00}) begin
                fails++;
                $display("FAIL blank_hold[%0d]: got yv=%b y=%h, want 1 00", i, y_valid, y);
            end
        end
        step();
        tests++;
        if (y_valid !== 1'b0) begin
            fails++;
            $display("FAIL blank_gap: got yv=%b, want 0", y_valid);
        end
        step();
        tests++;
        if ({y_valid, y} !== {1'b1, 8'h04}) begin
            fails++;
            $display("FAIL blank_next: got yv=%b y=%h, want 1 04", y_valid, y);
        end
        for (int i = 0; i < 5; i++) step();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL blank_done: got busy=%b, want 0", busy);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_clear();
        in_valid = 1'b1; in_en = 1'b1; in_code = 3'd1;
        step();
        in_code = 3'd2;
        step();                                   // first DRIVE cycle begins
        tests++;
        if ({y_valid, y, fifo_count} !== {1'b1, 8'h02, 3'd1}) begin
            fails++;
            $display("FAIL clear_pre: got yv=%b y=%h cnt=%0d, want 1 02 1", y_valid, y, fifo_count);
        end
        clear = 1'b1; in_code = 3'd3;             // concurrent push
        step();
        clear = 1'b0; in_valid = 1'b0;
        tests++;
        if ({y_valid, y, fifo_count, busy} !== {1'b0, 8'h00, 3'd0, 1'b0}) begin
            fails++;
            $display("FAIL clear_flush: got yv=%b y=%h cnt=%0d busy=%b, want 0 00 0 0",
                     y_valid, y, fifo_count, busy);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            tests++;
            if ({y_valid, y, fifo_count} !== {1'b0, 8'h00, 3'd0}) begin
                fails++;
                $display("FAIL clear_after[%0d]: got yv=%b y=%h cnt=%0d, want 0 00 0",
                         i, y_valid, y, fifo_count);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_async_reset();
        in_valid = 1'b1; in_en = 1'b1; in_code = 3'd7;
        step();
        in_code = 3'd4;
        step();
        in_valid = 1'b0;
        tests++;
        if ({y_valid, y, fifo_count} !== {1'b1, 8'h80, 3'd1}) begin
            fails++;
            $display("FAIL arst_pre: got yv=%b y=%h cnt=%0d, want 1 80 1", y_valid, y, fifo_count);
        end
        #2 rst_n = 1'b0;
        #1;                                       // still well before next edge
        tests++;
        if ({y_valid, y, fifo_count, busy, in_ready} !== {1'b0, 8'h00, 3'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL arst_now: got yv=%b y=%h cnt=%0d busy=%b rdy=%b, want 0 00 0 0 1",
                     y_valid, y, fifo_count, busy, in_ready);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            tests++;
            if ({y_valid, y, fifo_count} !== {1'b0, 8'h00, 3'd0}) begin
                fails++;
                $display("FAIL arst_stale[%0d]: got yv=%b y=%h cnt=%0d, want 0 00 0",
                         i, y_valid, y, fifo_count);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gapless();
        test_blank();
        test_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
